// File: rtl/exec_iter_ctrl_pkg.sv
// Shared encodings for the execute-stage multi-cycle MUL/DIVU/REMU sequencer.
// Default widths, operation codes and FSM states used by the controller and its datapath.
package exec_iter_ctrl_pkg;

  localparam int EIC_WIDTH = 16;
  localparam int EIC_CNT_W = 5;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REMU = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/exec_iter_ctrl_datapath.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide, one step per cycle.
// acc holds the product or partial remainder; sh holds the multiplicand or dividend/quotient.
module exec_iter_ctrl_datapath
  import exec_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = EIC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] result_next
);

  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sh_reg, sh_next;
  logic [WIDTH-1:0] mplr_reg, mplr_next;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] rem_shift;
  logic [WIDTH:0]   trial;

  // Multiplicand gated by the current multiplier LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_addend
      assign addend[gi] = sh_reg[gi] & mplr_reg[0];
    end
  endgenerate

  assign rem_shift = {acc_reg[WIDTH-2:0], sh_reg[WIDTH-1]};
  assign trial     = {1'b0, rem_shift} - {1'b0, mplr_reg};

  always_comb begin
    acc_next  = acc_reg;
    sh_next   = sh_reg;
    mplr_next = mplr_reg;
    if (load) begin
      acc_next  = '0;
      sh_next   = opa;
      mplr_next = opb;
    end else if (step) begin
      if (op == OP_MUL) begin
        acc_next  = acc_reg + addend;
        sh_next   = sh_reg << 1;
        mplr_next = mplr_reg >> 1;
      end else begin
        // mplr_reg keeps the divisor unchanged for the whole division.
        acc_next = trial[WIDTH] ? rem_shift : trial[WIDTH-1:0];
        sh_next  = {sh_reg[WIDTH-2:0], ~trial[WIDTH]};
      end
    end
  end

  // Value the result will take after this edge, so the controller can register it on entry to DONE.
  assign result_next = (op == OP_DIVU) ? sh_next : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      sh_reg   <= '0;
      mplr_reg <= '0;
    end else begin
      acc_reg  <= acc_next;
      sh_reg   <= sh_next;
      mplr_reg <= mplr_next;
    end
  end

endmodule

// File: rtl/exec_iter_ctrl.sv
// Execute-stage sequencer for 16-iteration MUL/DIVU/REMU beside the single-cycle ALU.
// Handles the request handshake, pipeline stall, flush abort and the divide-by-zero/reserved shortcuts.
module exec_iter_ctrl
  import exec_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = EIC_WIDTH,
  parameter int CNT_W = EIC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             err
);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [1:0]       op_reg, op_next;
  logic             err_reg, err_next;
  logic [WIDTH-1:0] res_data_reg, res_data_next;
  logic             load, step, accept;
  logic [WIDTH-1:0] result_next;

  exec_iter_ctrl_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .step       (step),
    .op         (op_reg),
    .opa        (opA),
    .opb        (opB),
    .result_next(result_next)
  );

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    op_next       = op_reg;
    err_next      = err_reg;
    res_data_next = res_data_reg;
    req_ready     = 1'b0;
    stall         = 1'b0;
    res_valid     = 1'b0;
    err           = 1'b0;
    load          = 1'b0;
    step          = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        req_ready = ~flush;
        accept    = req_valid & ~flush;
        stall     = accept;
        if (accept) begin
          load     = 1'b1;
          op_next  = req_op;
          cnt_next = '0;
          err_next = (req_op == OP_RSV);
          if (req_op == OP_RSV) begin
            state_next    = ST_DONE;
            res_data_next = '0;
          end else if (is_div_op(req_op) && (opB == '0)) begin
            state_next    = ST_DONE;
            res_data_next = (req_op == OP_DIVU) ? '1 : opA;
          end else begin
            state_next = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          step     = 1'b1;
          cnt_next = cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_next    = ST_DONE;
            res_data_next = result_next;
          end
        end
      end
      ST_DONE: begin
        res_valid  = ~flush;
        err        = err_reg & ~flush;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= OP_MUL;
      err_reg      <= 1'b0;
      res_data_reg <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      op_reg       <= op_next;
      err_reg      <= err_next;
      res_data_reg <= res_data_next;
    end
  end

  assign res_data = res_data_reg;

endmodule

// File: tb/tb_exec_iter_ctrl.sv
// Bench for exec_iter_ctrl: directed vectors, randomized ops against an arithmetic model,
// flush, back-to-back handshake and asynchronous reset scenarios.
module tb_exec_iter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] opA = 16'h0;
  logic [15:0] opB = 16'h0;
  logic        flush = 1'b0;
  logic        stall;
  logic        res_valid;
  logic [15:0] res_data;
  logic        err;

  int total = 0;
  int bad = 0;

  exec_iter_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .opA      (opA),
    .opB      (opB),
    .flush    (flush),
    .stall    (stall),
    .res_valid(res_valid),
    .res_data (res_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] model_data(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    prod = 32'(a) * 32'(b);
    case (op)
      2'b00:   return prod[15:0];
      2'b01:   return (b == 16'h0) ? 16'hFFFF : a / b;
      2'b10:   return (b == 16'h0) ? a : a % b;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [15:0] b);
    if (op == 2'b11 || (op != 2'b00 && b == 16'h0)) return 1;
    return 17;
  endfunction

  // Drives one request in the current cycle and checks handshake, stall timing and result.
  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] exp_data;
    logic        exp_err;
    int          lat;
    exp_data = model_data(op, a, b);
    exp_err  = (op == 2'b11);
    lat      = model_lat(op, b);
    req_valid = 1'b1; req_op = op; opA = a; opB = b;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || stall !== 1'b1) begin
      bad++;
      $display("FAIL accept: ready=%b stall=%b, required 1 1", req_ready, stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); opA = 16'($urandom); opB = 16'($urandom);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      total++;
      if (stall !== (cyc < lat) || res_valid !== (cyc == lat) || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL timing cycle %0d: stall=%b res_valid=%b ready=%b, required %b %b 0",
                 cyc, stall, res_valid, req_ready, (cyc < lat), (cyc == lat));
      end
      if (cyc < lat) begin
        @(posedge clk); #1;
      end
    end
    total++;
    if (res_data !== exp_data || err !== exp_err) begin
      bad++;
      $display("FAIL result op=%0d a=%h b=%h: data=%h err=%b, required %h %b",
               op, a, b, res_data, err, exp_data, exp_err);
    end
    $display("txn op=%0d a=%h b=%h lat=%0d data=%h err=%b expect=%h %b",
             op, a, b, lat, res_data, err, exp_data, exp_err);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0 || res_data !== 16'h0) begin
      bad++;
      $display("FAIL reset: ready=%b stall=%b valid=%b err=%b data=%h, required 1 0 0 0 0000",
               req_ready, stall, res_valid, err, res_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [1:0]  ops [9] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
    logic [15:0] as  [9] = '{16'd3, 16'hFFFF, 16'h1234, 16'd100, 16'd100, 16'hFFFF, 16'd9, 16'd9, 16'h5A5A};
    logic [15:0] bs  [9] = '{16'd5, 16'h0002, 16'h0100, 16'd7, 16'd7, 16'h0001, 16'd0, 16'd0, 16'h1111};
    for (int i = 0; i < 9; i++) run_txn(ops[i], as[i], bs[i]);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b = 16'h0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = a;
        default: b = 16'($urandom);
      endcase
      run_txn(op, a, b);
    end
  endtask

  task automatic test_flush();
    // Flush mid-MUL: aborted without a result, next request accepted right away.
    req_valid = 1'b1; req_op = 2'b00; opA = 16'($urandom); opB = 16'($urandom);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      if (cyc == 5) flush = 1'b1;
      @(negedge clk);
      total++;
      if (stall !== 1'b1 || res_valid !== 1'b0 || err !== 1'b0) begin
        bad++;
        $display("FAIL flush busy cycle %0d: stall=%b valid=%b err=%b, required 1 0 0", cyc, stall, res_valid, err);
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    run_txn(2'b01, 16'd100, 16'd7);
    // Flush in IDLE blocks acceptance.
    req_valid = 1'b1; req_op = 2'b00; flush = 1'b1;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush idle: ready=%b stall=%b, required 0 0", req_ready, stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || stall !== 1'b0) begin
      bad++;
      $display("FAIL flush idle after: ready=%b stall=%b, required 1 0", req_ready, stall);
    end
    @(posedge clk); #1;
    // Flush in DONE suppresses the strobe and err.
    req_valid = 1'b1; req_op = 2'b11; opA = 16'h1; opB = 16'h2;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    total++;
    if (res_valid !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL flush done: valid=%b err=%b, required 0 0", res_valid, err);
    end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush done after: ready=%b valid=%b, required 1 0", req_ready, res_valid);
    end
    $display("txn flush scenarios complete");
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [15:0] a1, b1, a2, b2, e1, e2;
    logic        exp_stall, exp_valid, exp_ready;
    a1 = 16'($urandom); b1 = 16'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom_range(1, 65535));
    e1 = model_data(2'b00, a1, b1);
    e2 = model_data(2'b01, a2, b2);
    for (int cyc = 0; cyc <= 35; cyc++) begin
      if (cyc == 0) begin
        req_valid = 1'b1; req_op = 2'b00; opA = a1; opB = b1;
      end else if (cyc == 1) begin
        req_op = 2'b01; opA = a2; opB = b2;
      end else if (cyc == 19) begin
        req_valid = 1'b0;
      end
      exp_stall = (cyc <= 16) || (cyc >= 18 && cyc <= 34);
      exp_valid = (cyc == 17) || (cyc == 35);
      exp_ready = (cyc == 0) || (cyc == 18);
      @(negedge clk);
      total++;
      if (stall !== exp_stall || res_valid !== exp_valid || req_ready !== exp_ready) begin
        bad++;
        $display("FAIL b2b cycle %0d: stall=%b valid=%b ready=%b, required %b %b %b",
                 cyc, stall, res_valid, req_ready, exp_stall, exp_valid, exp_ready);
      end
      if (cyc == 17 || cyc == 35) begin
        total++;
        if (res_data !== ((cyc == 17) ? e1 : e2)) begin
          bad++;
          $display("FAIL b2b result cycle %0d: data=%h, required %h", cyc, res_data, (cyc == 17) ? e1 : e2);
        end
      end
      @(posedge clk); #1;
    end
    $display("txn back-to-back mul %h*%h=%h divu %h/%h=%h", a1, b1, e1, a2, b2, e2);
  endtask

  task automatic test_async_reset();
    int stray;
    run_txn(2'b00, 16'd3, 16'd5);
    req_valid = 1'b1; req_op = 2'b00; opA = 16'h00FF; opB = 16'h0101;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1 || stall !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0 || res_data !== 16'h0) begin
      bad++;
      $display("FAIL async reset: ready=%b stall=%b valid=%b err=%b data=%h, required 1 0 0 0 0000",
               req_ready, stall, res_valid, err, res_data);
    end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    stray = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || stall !== 1'b0 || req_ready !== 1'b1) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL post reset idle: %0d non-idle cycles, required 0", stray);
    end
    $display("txn async reset mid-busy, non-idle cycles after release=%0d", stray);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_back_to_back();
    test_async_reset();
    run_txn(2'b10, 16'd100, 16'd7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
